// File: rtl/sseg_pkg.sv
// sseg_pkg: segment patterns, digit codes and FSM states shared by the display readback monitor
package sseg_pkg;
    localparam logic [7:0] SEG_PAT [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                             8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
    localparam logic [7:0] SEG_DASH  = 8'hFD;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] DIG_DASH    = 4'hE;
    localparam logic [3:0] DIG_BLANK   = 4'hF;
    localparam logic [3:0] DIG_ILLEGAL = 4'hD;
    localparam logic [1:0] SCAN = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    function automatic logic is_digit(input logic [3:0] c);
        return c < 4'd10;
    endfunction
endpackage

// File: rtl/sseg_seg2dig.sv
// sseg_seg2dig: active-low segment pattern to digit code, decimal point ignored
module sseg_seg2dig
    import sseg_pkg::*;
(
    input  logic [7:0] segments,
    output logic [3:0] code
);
    logic [7:0] m;
    assign m = segments | 8'h01;
    always_comb begin
        code = m == SEG_DASH ? DIG_DASH : m == SEG_BLANK ? DIG_BLANK : DIG_ILLEGAL;
        for (int i = 0; i < 10; i++) if (m == SEG_PAT[i]) code = 4'(i);
    end
endmodule

// File: rtl/sseg_capture.sv
// sseg_capture: rebuilds value/sign/valid/error frames from a multiplexed active-low 4-digit display
module sseg_capture
    import sseg_pkg::*;
#(
    parameter int SETTLE_CYC    = 4,
    parameter int STABLE_FRAMES = 2,
    parameter int VAL_W         = 14
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [3:0]       DISP_EN,
    input  logic [7:0]       SEGMENTS,
    output logic             FRAME_VLD,
    input  logic             FRAME_RDY,
    output logic [VAL_W-1:0] VAL_OUT,
    output logic             SIGN_OUT,
    output logic             VALID_OUT,
    output logic             ERR_OUT,
    output logic             DROP
);
    logic [3:0] prev_en, mask, match, nmatch, code, dv;
    logic [7:0] prev_seg, settle;
    logic [1:0] idx, state, k;
    logic [3:0][3:0] cur, prv, frm, last;
    logic [VAL_W-1:0] acc;
    logic last_vld, drop, one_low, sample, scan_done, qual, fresh, all_dash, bad, seen, err, hold;

    sseg_seg2dig u_dec (.segments(SEGMENTS), .code(code));

    assign one_low   = $countones(~DISP_EN) == 1;
    assign sample    = one_low && DISP_EN == prev_en && SEGMENTS == prev_seg && settle == 8'(SETTLE_CYC - 1);
    assign scan_done = mask == 4'hF;
    assign nmatch    = cur == prv ? match + 4'd1 : 4'd1;
    assign qual      = scan_done && nmatch >= 4'(STABLE_FRAMES);
    assign fresh     = qual && !(last_vld && cur == last);
    assign dv        = is_digit(frm[k]) ? frm[k] : 4'd0;
    assign hold      = state == HOLD;
    assign all_dash  = frm == {4{DIG_DASH}};

    always_comb begin
        idx = 2'd0;
        for (int i = 0; i < 4; i++) if (!DISP_EN[i]) idx = 2'(i);
    end

    // slot 0 is the leftmost digit; a blank is only legal before the first real digit
    always_comb begin
        bad  = !is_digit(frm[3]);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bad  = bad || frm[i] == DIG_ILLEGAL || (i != 0 && frm[i] == DIG_DASH) || (seen && frm[i] == DIG_BLANK);
            seen = seen || is_digit(frm[i]);
        end
        err = bad && !all_dash;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_en  <= '0;
            prev_seg <= '0;
            settle   <= '0;
            mask     <= '0;
            match    <= '0;
            cur      <= '0;
            prv      <= '0;
            frm      <= '0;
            last     <= '0;
            last_vld <= 1'b0;
            acc      <= '0;
            k        <= '0;
            drop     <= 1'b0;
            state    <= SCAN;
        end else begin
            prev_en  <= DISP_EN;
            prev_seg <= SEGMENTS;
            settle   <= (!one_low || DISP_EN != prev_en || SEGMENTS != prev_seg) ? 8'd0 :
                        settle < 8'(SETTLE_CYC) ? settle + 8'd1 : settle;
            drop     <= fresh && state != SCAN;
            if (scan_done) begin
                prv   <= cur;
                mask  <= 4'h0;
                match <= nmatch >= 4'(STABLE_FRAMES) ? 4'(STABLE_FRAMES) : nmatch;
            end
            if (sample) begin
                cur[idx]  <= code;
                mask[idx] <= 1'b1;
            end
            if (state == SCAN && fresh) begin
                frm   <= cur;
                acc   <= '0;
                k     <= 2'd0;
                state <= CONV;
            end else if (state == CONV) begin
                acc <= (acc << 3) + (acc << 1) + VAL_W'(dv);
                k   <= k + 2'd1;
                if (k == 2'd3) state <= HOLD;
            end else if (hold && FRAME_RDY) begin
                state    <= SCAN;
                last     <= frm;
                last_vld <= 1'b1;
            end
        end
    end

    assign FRAME_VLD = hold;
    assign VAL_OUT   = hold && !err ? acc : '0;
    assign SIGN_OUT  = hold && !err && !all_dash && frm[0] == DIG_DASH;
    assign VALID_OUT = hold && !all_dash;
    assign ERR_OUT   = hold && err;
    assign DROP      = drop;
endmodule
